// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register: holds control and datapath fields between execute and memory,
// with stall/flush handling, a branch/jump redirect request and a saturating bubble counter.
module exmem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [1:0]        wb_in,
    input  logic [2:0]        m_in,
    input  logic              jump_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [REG_W-1:0]  dest_reg_in,
    input  logic [ADDR_W-1:0] br_target_in,
    input  logic [ADDR_W-1:0] jmp_target_in,
    output logic              valid_out,
    output logic [1:0]        wb_out,
    output logic              branch_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              jump_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic              zero_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [REG_W-1:0]  dest_reg_out,
    output logic [ADDR_W-1:0] br_target_out,
    output logic [ADDR_W-1:0] jmp_target_out,
    output logic              pc_src_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_reg;
    logic [1:0]        wb_reg;
    logic              branch_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic              jump_reg;
    logic [DATA_W-1:0] alu_res_reg;
    logic              zero_reg;
    logic [DATA_W-1:0] store_data_reg;
    logic [REG_W-1:0]  dest_reg_reg;
    logic [ADDR_W-1:0] br_target_reg;
    logic [ADDR_W-1:0] jmp_target_reg;
    logic [CNT_W-1:0]  bubble_cnt_reg;
    logic [CNT_W-1:0]  bubble_cnt_next;

    // Counter stops at all-ones instead of wrapping.
    assign bubble_cnt_next = (&bubble_cnt_reg) ? bubble_cnt_reg : bubble_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= 1'b0;
            wb_reg         <= 2'b00;
            branch_reg     <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            jump_reg       <= 1'b0;
            alu_res_reg    <= '0;
            zero_reg       <= 1'b0;
            store_data_reg <= '0;
            dest_reg_reg   <= '0;
            br_target_reg  <= '0;
            jmp_target_reg <= '0;
            bubble_cnt_reg <= '0;
        end else if (flush) begin
            // Bubble: kill controls only; datapath keeps its last contents.
            valid_reg      <= 1'b0;
            wb_reg         <= 2'b00;
            branch_reg     <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            jump_reg       <= 1'b0;
            bubble_cnt_reg <= bubble_cnt_next;
        end else if (!stall) begin
            valid_reg      <= valid_in;
            wb_reg         <= valid_in ? wb_in : 2'b00;
            branch_reg     <= valid_in & m_in[2];
            mem_read_reg   <= valid_in & m_in[1];
            mem_write_reg  <= valid_in & m_in[0];
            jump_reg       <= valid_in & jump_in;
            alu_res_reg    <= alu_res_in;
            zero_reg       <= zero_in;
            store_data_reg <= store_data_in;
            dest_reg_reg   <= dest_reg_in;
            br_target_reg  <= br_target_in;
            jmp_target_reg <= jmp_target_in;
            if (!valid_in) begin
                bubble_cnt_reg <= bubble_cnt_next;
            end
        end
    end

    assign valid_out      = valid_reg;
    assign wb_out         = wb_reg;
    assign branch_out     = branch_reg;
    assign mem_read_out   = mem_read_reg;
    assign mem_write_out  = mem_write_reg;
    assign jump_out       = jump_reg;
    assign alu_res_out    = alu_res_reg;
    assign zero_out       = zero_reg;
    assign store_data_out = store_data_reg;
    assign dest_reg_out   = dest_reg_reg;
    assign br_target_out  = br_target_reg;
    assign jmp_target_out = jmp_target_reg;
    assign bubble_cnt     = bubble_cnt_reg;

    assign pc_src_out = valid_reg & ((branch_reg & zero_reg) | jump_reg);

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Directed testbench for exmem_pipe_reg; a second instance with CNT_W=2 covers counter saturation.
module tb_exmem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_in, jump_in, zero_in;
    logic [1:0]  wb_in;
    logic [2:0]  m_in;
    logic [31:0] alu_res_in, store_data_in, br_target_in, jmp_target_in;
    logic [4:0]  dest_reg_in;

    logic        valid_out, branch_out, mem_read_out, mem_write_out, jump_out, zero_out, pc_src_out;
    logic [1:0]  wb_out;
    logic [31:0] alu_res_out, store_data_out, br_target_out, jmp_target_out;
    logic [4:0]  dest_reg_out;
    logic [7:0]  bubble_cnt;

    logic        s_valid_out, s_branch_out, s_mem_read_out, s_mem_write_out, s_jump_out, s_zero_out, s_pc_src_out;
    logic [1:0]  s_wb_out;
    logic [31:0] s_alu_res_out, s_store_data_out, s_br_target_out, s_jmp_target_out;
    logic [4:0]  s_dest_reg_out;
    logic [1:0]  s_bubble_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_bubble;

    always #5 clk = ~clk;

    exmem_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .wb_in(wb_in), .m_in(m_in), .jump_in(jump_in), .alu_res_in(alu_res_in),
        .zero_in(zero_in), .store_data_in(store_data_in), .dest_reg_in(dest_reg_in),
        .br_target_in(br_target_in), .jmp_target_in(jmp_target_in),
        .valid_out(valid_out), .wb_out(wb_out), .branch_out(branch_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .jump_out(jump_out),
        .alu_res_out(alu_res_out), .zero_out(zero_out), .store_data_out(store_data_out),
        .dest_reg_out(dest_reg_out), .br_target_out(br_target_out),
        .jmp_target_out(jmp_target_out), .pc_src_out(pc_src_out), .bubble_cnt(bubble_cnt)
    );

    exmem_pipe_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .wb_in(wb_in), .m_in(m_in), .jump_in(jump_in), .alu_res_in(alu_res_in),
        .zero_in(zero_in), .store_data_in(store_data_in), .dest_reg_in(dest_reg_in),
        .br_target_in(br_target_in), .jmp_target_in(jmp_target_in),
        .valid_out(s_valid_out), .wb_out(s_wb_out), .branch_out(s_branch_out),
        .mem_read_out(s_mem_read_out), .mem_write_out(s_mem_write_out), .jump_out(s_jump_out),
        .alu_res_out(s_alu_res_out), .zero_out(s_zero_out), .store_data_out(s_store_data_out),
        .dest_reg_out(s_dest_reg_out), .br_target_out(s_br_target_out),
        .jmp_target_out(s_jmp_target_out), .pc_src_out(s_pc_src_out), .bubble_cnt(s_bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d rst=%b stall=%b flush=%b vin=%b | valid=%b wb=%b m=%b%b%b j=%b alu=%h pc_src=%b bubbles=%0d sat=%0d",
                 cyc, rst, stall, flush, valid_in, valid_out, wb_out, branch_out, mem_read_out,
                 mem_write_out, jump_out, alu_res_out, pc_src_out, bubble_cnt, s_bubble_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        checks++; if (alu_res_out !== 32'h0) begin errors++; $display("FAIL reset_alu got %h exp 0", alu_res_out); end
        checks++; if (bubble_cnt !== 8'd0) begin errors++; $display("FAIL reset_bubble got %0d exp 0", bubble_cnt); end
        checks++; if (pc_src_out !== 1'b0) begin errors++; $display("FAIL reset_pc_src got %b exp 0", pc_src_out); end
        rst = 1'b0;
        exp_bubble = 8'd0;
    endtask

    task automatic test_load();
        valid_in = 1'b1; wb_in = 2'b10; m_in = 3'b100; jump_in = 1'b0; zero_in = 1'b1;
        alu_res_in = 32'h0000_0010; dest_reg_in = 5'd9; store_data_in = 32'h1234_5678;
        br_target_in = 32'h0000_0100; jmp_target_in = 32'h0000_0200;
        tick();
        checks++; if (branch_out !== 1'b1) begin errors++; $display("FAIL load_branch got %b exp 1", branch_out); end
        checks++; if (alu_res_out !== 32'h10) begin errors++; $display("FAIL load_alu got %h exp 00000010", alu_res_out); end
        checks++; if (dest_reg_out !== 5'd9) begin errors++; $display("FAIL load_dest got %0d exp 9", dest_reg_out); end
        checks++; if (pc_src_out !== 1'b1) begin errors++; $display("FAIL load_pc_src got %b exp 1", pc_src_out); end
        checks++; if (wb_out !== 2'b10) begin errors++; $display("FAIL load_wb got %b exp 10", wb_out); end
        checks++; if (br_target_out !== 32'h100) begin errors++; $display("FAIL load_br_target got %h exp 00000100", br_target_out); end
        checks++; if (store_data_out !== 32'h1234_5678) begin errors++; $display("FAIL load_store got %h exp 12345678", store_data_out); end
        checks++; if (bubble_cnt !== exp_bubble) begin errors++; $display("FAIL load_bubble got %0d exp %0d", bubble_cnt, exp_bubble); end
        // Outputs must not follow inputs between edges.
        alu_res_in = 32'hFFFF_FFFF; zero_in = 1'b0;
        #3;
        checks++; if (alu_res_out !== 32'h10) begin errors++; $display("FAIL between_edges_alu got %h exp 00000010", alu_res_out); end
        checks++; if (pc_src_out !== 1'b1) begin errors++; $display("FAIL between_edges_pc_src got %b exp 1", pc_src_out); end
    endtask

    task automatic test_stall();
        valid_in = 1'b1; m_in = 3'b000; wb_in = 2'b10; alu_res_in = 32'hAAAA_0001;
        tick();
        checks++; if (alu_res_out !== 32'hAAAA_0001) begin errors++; $display("FAIL stall_preload got %h exp aaaa0001", alu_res_out); end
        stall = 1'b1; valid_in = 1'b0; alu_res_in = 32'h5555_0002;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (alu_res_out !== 32'hAAAA_0001) begin errors++; $display("FAIL stall_alu_%0d got %h exp aaaa0001", i, alu_res_out); end
            checks++; if (bubble_cnt !== exp_bubble) begin errors++; $display("FAIL stall_bubble_%0d got %0d exp %0d", i, bubble_cnt, exp_bubble); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d got %b exp 1", i, valid_out); end
        end
        stall = 1'b0;
    endtask

    task automatic test_flush_vs_stall();
        valid_in = 1'b1; jump_in = 1'b1; m_in = 3'b000; alu_res_in = 32'h0000_0077;
        jmp_target_in = 32'h0000_0400;
        tick();
        checks++; if (jump_out !== 1'b1) begin errors++; $display("FAIL fvs_jump_pre got %b exp 1", jump_out); end
        checks++; if (pc_src_out !== 1'b1) begin errors++; $display("FAIL fvs_pc_src_pre got %b exp 1", pc_src_out); end
        stall = 1'b1; flush = 1'b1; alu_res_in = 32'h0000_0088; jmp_target_in = 32'h0000_0800;
        tick();
        exp_bubble = exp_bubble + 8'd1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fvs_valid got %b exp 0", valid_out); end
        checks++; if (jump_out !== 1'b0) begin errors++; $display("FAIL fvs_jump got %b exp 0", jump_out); end
        checks++; if (pc_src_out !== 1'b0) begin errors++; $display("FAIL fvs_pc_src got %b exp 0", pc_src_out); end
        checks++; if (alu_res_out !== 32'h77) begin errors++; $display("FAIL fvs_alu got %h exp 00000077", alu_res_out); end
        checks++; if (jmp_target_out !== 32'h400) begin errors++; $display("FAIL fvs_jmp_target got %h exp 00000400", jmp_target_out); end
        checks++; if (bubble_cnt !== exp_bubble) begin errors++; $display("FAIL fvs_bubble got %0d exp %0d", bubble_cnt, exp_bubble); end
        stall = 1'b0; flush = 1'b0; jump_in = 1'b0;
    endtask

    task automatic test_bubble_load();
        valid_in = 1'b0; wb_in = 2'b11; m_in = 3'b011; jump_in = 1'b1;
        store_data_in = 32'hDEAD_BEEF; alu_res_in = 32'h0000_0099;
        tick();
        exp_bubble = exp_bubble + 8'd1;
        checks++; if (wb_out !== 2'b00) begin errors++; $display("FAIL bubble_wb got %b exp 00", wb_out); end
        checks++; if (mem_write_out !== 1'b0) begin errors++; $display("FAIL bubble_mem_write got %b exp 0", mem_write_out); end
        checks++; if (mem_read_out !== 1'b0) begin errors++; $display("FAIL bubble_mem_read got %b exp 0", mem_read_out); end
        checks++; if (jump_out !== 1'b0) begin errors++; $display("FAIL bubble_jump got %b exp 0", jump_out); end
        checks++; if (store_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bubble_store got %h exp deadbeef", store_data_out); end
        checks++; if (alu_res_out !== 32'h99) begin errors++; $display("FAIL bubble_alu got %h exp 00000099", alu_res_out); end
        checks++; if (bubble_cnt !== exp_bubble) begin errors++; $display("FAIL bubble_cnt got %0d exp %0d", bubble_cnt, exp_bubble); end
        jump_in = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat [5];
        exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_bubble = 8'd0;
        valid_in = 1'b1;
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_bubble = exp_bubble + 8'd1;
            checks++; if (s_bubble_cnt !== exp_sat[i]) begin errors++; $display("FAIL sat_cnt_%0d got %0d exp %0d", i, s_bubble_cnt, exp_sat[i]); end
            checks++; if (bubble_cnt !== exp_bubble) begin errors++; $display("FAIL wide_cnt_%0d got %0d exp %0d", i, bubble_cnt, exp_bubble); end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_priority();
        valid_in = 1'b1; wb_in = 2'b10; m_in = 3'b100; zero_in = 1'b1; jump_in = 1'b0;
        alu_res_in = 32'h0000_CAFE; store_data_in = 32'h0BAD_F00D; dest_reg_in = 5'd17;
        tick();
        checks++; if (pc_src_out !== 1'b1) begin errors++; $display("FAIL rp_pc_src_pre got %b exp 1", pc_src_out); end
        rst = 1'b1; flush = 1'b1; stall = 1'b1;
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rp_valid got %b exp 0", valid_out); end
        checks++; if (branch_out !== 1'b0) begin errors++; $display("FAIL rp_branch got %b exp 0", branch_out); end
        checks++; if (alu_res_out !== 32'h0) begin errors++; $display("FAIL rp_alu got %h exp 0", alu_res_out); end
        checks++; if (store_data_out !== 32'h0) begin errors++; $display("FAIL rp_store got %h exp 0", store_data_out); end
        checks++; if (dest_reg_out !== 5'd0) begin errors++; $display("FAIL rp_dest got %0d exp 0", dest_reg_out); end
        checks++; if (zero_out !== 1'b0) begin errors++; $display("FAIL rp_zero got %b exp 0", zero_out); end
        checks++; if (pc_src_out !== 1'b0) begin errors++; $display("FAIL rp_pc_src got %b exp 0", pc_src_out); end
        checks++; if (bubble_cnt !== 8'd0) begin errors++; $display("FAIL rp_bubble got %0d exp 0", bubble_cnt); end
        checks++; if (s_bubble_cnt !== 2'd0) begin errors++; $display("FAIL rp_sat_bubble got %0d exp 0", s_bubble_cnt); end
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        valid_in = 1'b1; wb_in = 2'b01; m_in = 3'b010; zero_in = 1'b0;
        alu_res_in = 32'h0000_1357; dest_reg_in = 5'd3;
        tick();
        checks++; if (alu_res_out !== 32'h1357) begin errors++; $display("FAIL rp_load_alu got %h exp 00001357", alu_res_out); end
        checks++; if (dest_reg_out !== 5'd3) begin errors++; $display("FAIL rp_load_dest got %0d exp 3", dest_reg_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rp_load_valid got %b exp 1", valid_out); end
        checks++; if (mem_read_out !== 1'b1) begin errors++; $display("FAIL rp_load_mem_read got %b exp 1", mem_read_out); end
        checks++; if (wb_out !== 2'b01) begin errors++; $display("FAIL rp_load_wb got %b exp 01", wb_out); end
        checks++; if (bubble_cnt !== 8'd0) begin errors++; $display("FAIL rp_load_bubble got %0d exp 0", bubble_cnt); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; jump_in = 1'b0; zero_in = 1'b0;
        wb_in = 2'b00; m_in = 3'b000; alu_res_in = '0; store_data_in = '0;
        br_target_in = '0; jmp_target_in = '0; dest_reg_in = '0; exp_bubble = 8'd0;
        test_reset();
        test_load();
        test_stall();
        test_flush_vs_stall();
        test_bubble_load();
        test_saturation();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
